conv_dot_product: RTL and testbench
===================================

Name: conv_dot_product

Overview:
- Downstream neighbour of the convolution window buffer; consumes one N×N window per cycle and produces the signed dot product with a stored N×N kernel.
- Fully pipelined: a product stage followed by a registered adder tree. It accepts a window every cycle with no backpressure, because the upstream buffer has no ready input.
- Kernel weights are loaded serially through a small load FSM before windows are streamed in.
- Optional ReLU on the output.

Parameters:
- N, 3, kernel side length; N*N taps.
- BitSize, 8, signed width of each window element.
- WeightSize, 8, signed width of each kernel weight.
- AccSize, BitSize+WeightSize+$clog2(N*N), signed result width. Sized so that no overflow is possible.
- Relu, 0, when 1, negative results are output as 0.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  asynchronous, active-high reset.
- w_valid  in  1  the weight word on w_data is written this cycle.
- w_data  in  WeightSize  signed weight, written in tap order k = 0..N*N-1.
- w_loaded  out  1  high when all N*N weights are loaded (state READY).
- in_valid  in  1  window on in_data is valid.
- in_data  in  N*N*BitSize  window; tap k = in_data[k*BitSize +: BitSize], with k = row*N + col.
- in_done  in  1  marks the last window of an image; sampled only with in_valid.
- out_valid  out  1  out_data is valid.
- out_data  out  AccSize  signed dot product, after ReLU if enabled.
- out_done  out  1  high together with the result of the window that carried in_done.
- drop_err  out  1  sticky flag: a window arrived while not READY.

Behaviour:
- Reset (async, res=1):
  - Weight registers, load counter, all pipeline data and valid bits, and drop_err clear to 0.
  - State goes to EMPTY.
  - Outputs: w_loaded=0, out_valid=0, out_done=0, out_data=0, drop_err=0.
  - A reset mid-stream discards every in-flight window; no partial results appear afterwards.
- Load FSM states: EMPTY, LOADING, READY.
  - EMPTY or LOADING, w_valid=1: write weight[cnt], then cnt++.
  - When the write hits index N*N-1: go to READY and set cnt=0. Otherwise the state is LOADING.
  - READY, w_valid=1: start a new load. Write weight[0], set cnt=1, state LOADING (READY if N*N==1), w_loaded drops next cycle.
  - w_valid=0: no change. Partial loads persist indefinitely.
- Window acceptance:
  - A window is accepted only when in_valid=1 and the state is READY at that rising edge.
  - When in_valid=1 and the state is not READY:
    - the window is dropped;
    - drop_err sets and stays set until reset;
    - in_done is ignored for that window.
  - If in_valid and w_valid are both high in READY, the window uses the old weights (the weight write and the product capture occur on the same edge). The state then leaves READY.
- Pipeline:
  - Stage P registers N*N signed products, each BitSize+WeightSize bits wide.
  - Then L = $clog2(N*N) registered adder levels, each pairwise and sign-extended to AccSize. An odd leftover passes through its level registered.
  - The final level feeds a ReLU mux and then the out_data register.
  - Latency LAT = L+2 (N=3: LAT=6). A window accepted at edge t gives out_valid high for exactly one cycle after edge t+LAT-1.
  - Throughput is one window per cycle. Back-to-back inputs give back-to-back outputs.
  - Valid and done bits travel the same depth as the data. out_done is never high while out_valid is low.
  - out_data holds its last value while out_valid=0.
- Arithmetic:
  - All operands are signed two's complement; products are exact.
  - ReLU: if Relu=1 and the sum is below 0, out_data=0; otherwise out_data is the sum.
- No backpressure: the consumer must accept out_valid every cycle.

Test Plan:
- N=3, Relu=0: load weights all 1, then one window of all 2 with in_done=1.
  - Expect w_loaded high after the 9th w_valid.
  - Expect out_valid=1, out_data=18 and out_done=1 exactly LAT=6 cycles after acceptance; out_valid=0 elsewhere.
- Weights zero except k=4 = 3; window with element 4 = -5, others 7.
  - Relu=0: expect -15.
  - Relu=1 (second build): expect out_data=0 with out_valid=1.
- Extreme values: weights all -128, window all -128.
  - Expect 147456 (fits in AccSize=19) with no wrap.
- Throughput: 4 consecutive windows with all weights 1 and element values 1, 2, 3, 4.
  - Expect 4 consecutive out_valid cycles with 9, 18, 27, 36; out_done only on the 4th when in_done is sent with the 4th.
- Not loaded: in_valid before any weights.
  - Expect drop_err=1, sticky, and no out_valid.
  - Reload mid-stream: w_valid coincident with a window in READY; that window's result uses the old weights, and windows following it while LOADING are dropped.
- Reset: assert res 2 cycles after accepting a window.
  - Expect all outputs 0 immediately (async) and no out_valid after release.
  - Expect w_loaded=0 after release, so weights must be reloaded.

Source files
------------

// File: rtl/conv_dot_product_if.sv
// Stream bundle between the window buffer, the dot-product engine and its consumer:
// serial weight load, window input and result output.
interface conv_dot_product_if #(
    parameter int N          = 3,
    parameter int BitSize    = 8,
    parameter int WeightSize = 8,
    parameter int AccSize    = BitSize + WeightSize + $clog2(N * N)
);
    logic                      w_valid;
    logic [WeightSize-1:0]     w_data;
    logic                      w_loaded;
    logic                      in_valid;
    logic [N*N*BitSize-1:0]    in_data;
    logic                      in_done;
    logic                      out_valid;
    logic [AccSize-1:0]        out_data;
    logic                      out_done;
    logic                      drop_err;

    modport master (
        output w_valid, w_data, in_valid, in_data, in_done,
        input  w_loaded, out_valid, out_data, out_done, drop_err
    );

    modport slave (
        input  w_valid, w_data, in_valid, in_data, in_done,
        output w_loaded, out_valid, out_data, out_done, drop_err
    );
endinterface

// File: rtl/conv_dot_product.sv
// Pipelined signed dot product of an N x N window with a serially loaded kernel:
// one product stage, a registered pairwise adder tree, optional ReLU, output register.
module conv_dot_product #(
    parameter int N          = 3,
    parameter int BitSize    = 8,
    parameter int WeightSize = 8,
    parameter int AccSize    = BitSize + WeightSize + $clog2(N * N),
    parameter int Relu       = 0
) (
    input  logic               clk,
    input  logic               res,
    conv_dot_product_if.slave  bus
);

    localparam int NN = N * N;
    localparam int PW = BitSize + WeightSize;
    localparam int L  = $clog2(NN);
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } state_t;

    state_t                     state_reg, state_next;
    logic [CW-1:0]              cnt_reg, cnt_next;
    logic                       w_we;
    logic [CW-1:0]              w_idx;
    logic signed [WeightSize-1:0] weight_reg [NN];
    logic                       drop_err_reg;
    logic                       accept;

    logic signed [PW-1:0]       prod_next [NN];
    logic signed [PW-1:0]       prod_reg  [NN];
    logic signed [AccSize-1:0]  tree_reg  [1:L][NN];
    logic signed [AccSize-1:0]  lvl_d     [0:L][NN];
    logic [L:0]                 vld_pipe_reg;
    logic [L:0]                 done_pipe_reg;

    logic signed [AccSize-1:0]  sum_final;
    logic signed [AccSize-1:0]  relu_next;
    logic signed [AccSize-1:0]  out_data_reg;
    logic                       out_valid_reg;
    logic                       out_done_reg;

    // Number of live operands at tree level l (ceil of NN / 2^l).
    function automatic int lvl_cnt(input int l);
        return (NN + (1 << l) - 1) >> l;
    endfunction

    function automatic int clip(input int i);
        return (i < NN) ? i : NN - 1;
    endfunction

    // ---------------- weight load FSM ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        w_we       = 1'b0;
        w_idx      = cnt_reg;
        if (bus.w_valid) begin
            w_we  = 1'b1;
            // A write while READY restarts the load from tap 0.
            w_idx = (state_reg == READY) ? '0 : cnt_reg;
            if (w_idx == LAST_IDX) begin
                state_next = READY;
                cnt_next   = '0;
            end else begin
                state_next = LOADING;
                cnt_next   = w_idx + 1'b1;
            end
        end
    end

    assign accept = bus.in_valid && (state_reg == READY);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg    <= EMPTY;
            cnt_reg      <= '0;
            drop_err_reg <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                weight_reg[k] <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (bus.in_valid && (state_reg != READY)) begin
                drop_err_reg <= 1'b1;
            end
            for (int k = 0; k < NN; k++) begin
                if (w_we && (w_idx == CW'(k))) begin
                    weight_reg[k] <= bus.w_data;
                end
            end
        end
    end

    // ---------------- product stage ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_mul
            assign prod_next[gi] = PW'($signed(bus.in_data[gi*BitSize +: BitSize]))
                                 * PW'(weight_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int k = 0; k < NN; k++) begin
                prod_reg[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NN; k++) begin
                prod_reg[k] <= prod_next[k];
            end
        end
    end

    // ---------------- adder tree ----------------
    always_comb begin
        for (int j = 0; j < NN; j++) begin
            lvl_d[0][j] = AccSize'(prod_reg[j]);
        end
        for (int l = 1; l <= L; l++) begin
            for (int j = 0; j < NN; j++) begin
                lvl_d[l][j] = tree_reg[l][j];
            end
        end
    end

    // Slots beyond a level's live count stay zero so they are trimmed away.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int l = 1; l <= L; l++) begin
                for (int j = 0; j < NN; j++) begin
                    tree_reg[l][j] <= '0;
                end
            end
        end else begin
            for (int l = 1; l <= L; l++) begin
                for (int j = 0; j < NN; j++) begin
                    if (j < lvl_cnt(l)) begin
                        if (2 * j + 1 < lvl_cnt(l - 1)) begin
                            tree_reg[l][j] <= lvl_d[l-1][clip(2 * j)]
                                            + lvl_d[l-1][clip(2 * j + 1)];
                        end else begin
                            tree_reg[l][j] <= lvl_d[l-1][clip(2 * j)];
                        end
                    end else begin
                        tree_reg[l][j] <= '0;
                    end
                end
            end
        end
    end

    // ---------------- valid/done shadow pipeline ----------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vld_pipe_reg  <= '0;
            done_pipe_reg <= '0;
        end else begin
            vld_pipe_reg  <= {vld_pipe_reg[L-1:0], accept};
            done_pipe_reg <= {done_pipe_reg[L-1:0], accept && bus.in_done};
        end
    end

    // ---------------- ReLU and output register ----------------
    assign sum_final = lvl_d[L][0];

    always_comb begin
        relu_next = sum_final;
        if ((Relu != 0) && sum_final[AccSize-1]) begin
            relu_next = '0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_valid_reg <= 1'b0;
            out_done_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= vld_pipe_reg[L];
            out_done_reg  <= vld_pipe_reg[L] && done_pipe_reg[L];
            if (vld_pipe_reg[L]) begin
                out_data_reg <= relu_next;
            end
        end
    end

    assign bus.w_loaded  = (state_reg == READY);
    assign bus.out_valid = out_valid_reg;
    assign bus.out_done  = out_done_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.drop_err  = drop_err_reg;

endmodule

// File: tb/tb_conv_dot_product.sv
// Directed bench: a plain and a ReLU instance share one stimulus stream.
module tb_conv_dot_product;

    localparam int N  = 3;
    localparam int NN = N * N;
    localparam int BS = 8;
    localparam int WS = 8;
    localparam int AS = 19;

    logic clk = 1'b0;
    logic res;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    conv_dot_product_if #(.N(N), .BitSize(BS), .WeightSize(WS), .AccSize(AS)) bus_a ();
    conv_dot_product_if #(.N(N), .BitSize(BS), .WeightSize(WS), .AccSize(AS)) bus_b ();

    assign bus_b.w_valid  = bus_a.w_valid;
    assign bus_b.w_data   = bus_a.w_data;
    assign bus_b.in_valid = bus_a.in_valid;
    assign bus_b.in_data  = bus_a.in_data;
    assign bus_b.in_done  = bus_a.in_done;

    conv_dot_product #(.N(N), .BitSize(BS), .WeightSize(WS), .AccSize(AS), .Relu(0)) dut (
        .clk (clk),
        .res (res),
        .bus (bus_a)
    );

    conv_dot_product #(.N(N), .BitSize(BS), .WeightSize(WS), .AccSize(AS), .Relu(1)) dut_relu (
        .clk (clk),
        .res (res),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN*BS-1:0] fill(input logic [BS-1:0] v);
        logic [NN*BS-1:0] d;
        for (int k = 0; k < NN; k++) d[k*BS +: BS] = v;
        return d;
    endfunction

    task automatic load_weights(input logic [NN*WS-1:0] w);
        for (int k = 0; k < NN; k++) begin
            bus_a.w_valid = 1'b1;
            bus_a.w_data  = w[k*WS +: WS];
            tick();
            if (k == 0 || k == NN - 2) check("w_loaded_partial", bus_a.w_loaded, 0);
        end
        bus_a.w_valid = 1'b0;
        bus_a.w_data  = '0;
        check("w_loaded_full", bus_a.w_loaded, 1);
        $display("[TB] weights loaded, w_loaded=%0b", bus_a.w_loaded);
    endtask

    task automatic one_window(input string tag, input logic [NN*BS-1:0] win, input logic done,
                              input int exp_a, input int exp_b);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = win;
        bus_a.in_done  = done;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_done  = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check({tag, "_valid"}, bus_a.out_valid, (i == 5));
            check({tag, "_done"}, bus_a.out_done, (i == 5) && done);
            if (i == 5) begin
                check({tag, "_data"}, $signed(bus_a.out_data), exp_a);
                check({tag, "_relu_valid"}, bus_b.out_valid, 1);
                check({tag, "_relu_data"}, $signed(bus_b.out_data), exp_b);
                $display("[TB] %s: out_data=%0d relu_out=%0d", tag,
                         $signed(bus_a.out_data), $signed(bus_b.out_data));
            end
        end
        check({tag, "_hold"}, $signed(bus_a.out_data), exp_a);
    endtask

    initial begin
        logic [NN*BS-1:0] w;
        logic [NN*BS-1:0] win;

        res            = 1'b1;
        bus_a.w_valid  = 1'b0;
        bus_a.w_data   = '0;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_a.in_done  = 1'b0;
        tick();
        tick();
        check("rst_w_loaded", bus_a.w_loaded, 0);
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_done", bus_a.out_done, 0);
        check("rst_out_data", $signed(bus_a.out_data), 0);
        check("rst_drop_err", bus_a.drop_err, 0);
        res = 1'b0;
        tick();

        // Window before any weights: dropped, sticky error.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = fill(8'd1);
        bus_a.in_done  = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_done  = 1'b0;
        check("noload_drop_err", bus_a.drop_err, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("noload_out_valid", bus_a.out_valid, 0);
        end
        check("noload_drop_sticky", bus_a.drop_err, 1);
        $display("[TB] unloaded window: drop_err=%0b", bus_a.drop_err);

        load_weights(fill(8'd1));
        one_window("basic", fill(8'd2), 1'b1, 18, 18);

        w = '0;
        w[4*WS +: WS] = 8'd3;
        load_weights(w);
        win = fill(8'd7);
        win[4*BS +: BS] = 8'hFB;
        one_window("neg", win, 1'b0, -15, 0);

        load_weights(fill(8'h80));
        one_window("extreme", fill(8'h80), 1'b0, 147456, 147456);

        // Four back-to-back windows; done with the last one.
        load_weights(fill(8'd1));
        for (int i = 0; i < 12; i++) begin
            int widx;
            if (i < 4) begin
                bus_a.in_valid = 1'b1;
                bus_a.in_data  = fill(BS'(i + 1));
                bus_a.in_done  = (i == 3);
            end else begin
                bus_a.in_valid = 1'b0;
                bus_a.in_done  = 1'b0;
            end
            tick();
            widx = i - 5;
            check("tput_valid", bus_a.out_valid, (widx >= 0 && widx < 4));
            check("tput_done", bus_a.out_done, (i == 8));
            if (widx >= 0 && widx < 4) begin
                check("tput_data", $signed(bus_a.out_data), 9 * (widx + 1));
                $display("[TB] tput window %0d: out_data=%0d out_done=%0b", widx,
                         $signed(bus_a.out_data), bus_a.out_done);
            end
        end

        // Reload coincident with an accepted window; the rest are dropped while loading.
        for (int i = 0; i < 15; i++) begin
            if (i <= 8) begin
                bus_a.w_valid  = 1'b1;
                bus_a.w_data   = 8'd2;
                bus_a.in_valid = 1'b1;
                bus_a.in_data  = (i == 0) ? fill(8'd5) : fill(8'd3);
            end else begin
                bus_a.w_valid  = 1'b0;
                bus_a.in_valid = 1'b0;
            end
            tick();
            check("reload_valid", bus_a.out_valid, (i == 5));
            if (i == 5) begin
                check("reload_old_weights", $signed(bus_a.out_data), 45);
                $display("[TB] reload: coincident window out_data=%0d", $signed(bus_a.out_data));
            end
        end
        check("reload_w_loaded", bus_a.w_loaded, 1);
        one_window("reloaded", fill(8'd1), 1'b0, 18, 18);

        // Reset two cycles after accepting a window.
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = fill(8'd1);
        tick();
        bus_a.in_valid = 1'b0;
        tick();
        tick();
        res = 1'b1;
        #2;
        check("arst_w_loaded", bus_a.w_loaded, 0);
        check("arst_out_valid", bus_a.out_valid, 0);
        check("arst_out_done", bus_a.out_done, 0);
        check("arst_out_data", $signed(bus_a.out_data), 0);
        check("arst_drop_err", bus_a.drop_err, 0);
        check("arst_relu_data", $signed(bus_b.out_data), 0);
        $display("[TB] async reset: out_data=%0d w_loaded=%0b", $signed(bus_a.out_data),
                 bus_a.w_loaded);
        tick();
        res = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_valid", bus_a.out_valid, 0);
        end
        check("post_rst_w_loaded", bus_a.w_loaded, 0);
        bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        check("post_rst_drop", bus_a.drop_err, 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("post_rst_drop_valid", bus_a.out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
